// File: rtl/demux_stream.sv
// Valid/ready stream demultiplexer: one-entry output register per channel, latency 1.
// Optional DEMUX_STREAM_DROPCNT_EN adds a saturating count of beats discarded for out-of-range selects.
module demux_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CH    = 8,
  parameter int unsigned SW    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    in_data,
  input  logic [SW-1:0]       in_sel,
  input  logic                in_valid,
  output logic                in_ready,
`ifdef DEMUX_STREAM_DROPCNT_EN
  output logic [7:0]          drop_cnt,
`endif
  output logic [CH*WIDTH-1:0] out_data,
  output logic [CH-1:0]       out_valid,
  input  logic [CH-1:0]       out_ready
);

  logic [CH-1:0]       r_valid;
  logic [CH*WIDTH-1:0] r_data;
  logic [CH-1:0]       w_hit;
  logic                w_sel_ok;
  logic [CH-1:0]       w_in_xfer;

  // One-hot channel decode; all-zero when in_sel addresses a nonexistent channel.
  always_comb begin
    w_hit = '0;
    for (int k = 0; k < CH; k++) begin
      w_hit[k] = (in_sel == SW'(k));
    end
  end

  assign w_sel_ok  = |w_hit;
  assign in_ready  = !w_sel_ok | (|(w_hit & (~r_valid | out_ready)));
  assign w_in_xfer = {CH{in_valid & in_ready}} & w_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_in_xfer | (r_valid & ~out_ready);
      for (int k = 0; k < CH; k++) begin
        if (w_in_xfer[k]) begin
          r_data[k*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;

`ifdef DEMUX_STREAM_DROPCNT_EN
  logic [7:0] r_drop_cnt;
  logic       w_drop;

  // Out-of-range beats are always accepted, so in_valid alone marks a discard.
  assign w_drop = in_valid & !w_sel_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Directed self-checking bench for demux_stream: default 8-channel instance plus a
// 6-channel instance exercising out-of-range select discard.
module tb_demux_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic [7:0]  out_valid;
  logic [7:0]  out_ready;

  logic [7:0]  d1_in_data;
  logic [2:0]  d1_in_sel;
  logic        d1_in_valid;
  logic        d1_in_ready;
  logic [47:0] d1_out_data;
  logic [5:0]  d1_out_valid;
  logic [5:0]  d1_out_ready;
`ifdef DEMUX_STREAM_DROPCNT_EN
  logic [7:0]  d0_drop_cnt;
  logic [7:0]  d1_drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_stream #(.WIDTH(8), .CH(8), .SW(3)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef DEMUX_STREAM_DROPCNT_EN
    .drop_cnt  (d0_drop_cnt),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  demux_stream #(.WIDTH(8), .CH(6), .SW(3)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (d1_in_data),
    .in_sel    (d1_in_sel),
    .in_valid  (d1_in_valid),
    .in_ready  (d1_in_ready),
`ifdef DEMUX_STREAM_DROPCNT_EN
    .drop_cnt  (d1_drop_cnt),
`endif
    .out_data  (d1_out_data),
    .out_valid (d1_out_valid),
    .out_ready (d1_out_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ch(input int k);
    return out_data[k*8 +: 8];
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] d);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 8'h00);
    out_ready    = 8'hFF;
    d1_in_data   = 8'h00;
    d1_in_sel    = 3'd0;
    d1_in_valid  = 1'b0;
    d1_out_ready = 6'h3F;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_out_data", out_data, 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
`ifdef DEMUX_STREAM_DROPCNT_EN
    check("rst_drop_cnt", 64'(d1_drop_cnt), 64'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Single beat 0xA5 to channel 3
    drive(1'b1, 3'd3, 8'hA5);
    #1 check("single_in_ready", 64'(in_ready), 64'h1);
    tick();
    check("single_valid", 64'(out_valid), 64'h08);
    check("single_data", 64'(ch(3)), 64'hA5);
    drive(1'b0, 3'd0, 8'h00);
    tick();
    check("single_valid_gone", 64'(out_valid), 64'h00);
    check("single_data_hold", 64'(ch(3)), 64'hA5);

    // Channel 5 backpressure
    out_ready = 8'hDF;
    drive(1'b1, 3'd5, 8'h11);
    #1 check("bp_first_ready", 64'(in_ready), 64'h1);
    tick();
    check("bp_first_valid", 64'(out_valid), 64'h20);
    check("bp_first_data", 64'(ch(5)), 64'h11);
    drive(1'b1, 3'd5, 8'h22);
    #1 check("bp_second_blocked", 64'(in_ready), 64'h0);
    tick();
    tick();
    check("bp_hold_valid", 64'(out_valid), 64'h20);
    check("bp_hold_data", 64'(ch(5)), 64'h11);
    out_ready = 8'hFF;
    #1 check("bp_release_ready", 64'(in_ready), 64'h1);
    tick();
    check("bp_second_valid", 64'(out_valid), 64'h20);
    check("bp_second_data", 64'(ch(5)), 64'h22);
    drive(1'b0, 3'd0, 8'h00);
    tick();
    check("bp_drained", 64'(out_valid), 64'h00);

    // Stalled channel 2 does not block channel 6
    out_ready = 8'hFB;
    drive(1'b1, 3'd2, 8'h44);
    tick();
    drive(1'b1, 3'd6, 8'h33);
    #1 check("indep_ready", 64'(in_ready), 64'h1);
    tick();
    check("indep_valid", 64'(out_valid), 64'h44);
    check("indep_ch6", 64'(ch(6)), 64'h33);
    check("indep_ch2", 64'(ch(2)), 64'h44);
    drive(1'b0, 3'd0, 8'h00);
    tick();
    check("indep_ch2_stalled", 64'(out_valid), 64'h04);
    out_ready = 8'hFF;
    tick();
    check("indep_ch2_drained", 64'(out_valid), 64'h00);

    // Full-throughput stream to channel 0
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'd0, 8'(i));
      #1 check($sformatf("stream_ready_%0d", i), 64'(in_ready), 64'h1);
      tick();
      check($sformatf("stream_valid_%0d", i), 64'(out_valid), 64'h01);
      check($sformatf("stream_data_%0d", i), 64'(ch(0)), 64'(i));
    end
    drive(1'b0, 3'd0, 8'h00);
    tick();
    check("stream_end", 64'(out_valid), 64'h00);

    // Out-of-range select discard on 6-channel instance
    d1_in_valid = 1'b1;
    d1_in_sel   = 3'd7;
    for (int i = 0; i < 300; i++) begin
      d1_in_data = 8'(i);
      #1 check($sformatf("drop_ready_%0d", i), 64'(d1_in_ready), 64'h1);
      tick();
      check($sformatf("drop_no_valid_%0d", i), 64'(d1_out_valid), 64'h0);
`ifdef DEMUX_STREAM_DROPCNT_EN
      if (i == 9) check("drop_cnt_10", 64'(d1_drop_cnt), 64'd10);
`endif
    end
    d1_in_valid = 1'b0;
`ifdef DEMUX_STREAM_DROPCNT_EN
    check("drop_cnt_sat", 64'(d1_drop_cnt), 64'd255);
`endif
    check("drop_data_untouched", 64'(d1_out_data), 64'h0);
    d1_in_sel = 3'd4;
    d1_out_ready = 6'h00;
    d1_in_valid = 1'b1;
    d1_in_data = 8'h6C;
    tick();
    d1_in_valid = 1'b0;
    check("d1_ch4_valid", 64'(d1_out_valid), 64'h10);
    check("d1_ch4_data", 64'(d1_out_data[32 +: 8]), 64'h6C);
    d1_out_ready = 6'h3F;

    // Asynchronous reset while channels 1 and 4 are full
    out_ready = 8'h00;
    drive(1'b1, 3'd1, 8'h71);
    tick();
    drive(1'b1, 3'd4, 8'h74);
    tick();
    drive(1'b0, 3'd0, 8'h00);
    check("pre_rst_valid", 64'(out_valid), 64'h12);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'h00);
    check("async_rst_data", out_data, 64'h0);
    check("async_rst_d1_valid", 64'(d1_out_valid), 64'h0);
    out_ready = 8'hFF;
    drive(1'b1, 3'd7, 8'h5A);
    tick();
    check("rst_no_xfer", 64'(out_valid), 64'h00);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_first_edge", 64'(out_valid), 64'h80);
    check("post_rst_data", 64'(ch(7)), 64'h5A);
    check("post_rst_ch1_lost", 64'(ch(1)), 64'h00);
    drive(1'b0, 3'd0, 8'h00);
    tick();
    check("post_rst_idle", 64'(out_valid), 64'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per beat (1..64).
REQ-002 The block SHALL have parameter CH, default 8, number of output channels (2..16).
REQ-003 The block SHALL have parameter SW, default 3, select width; it SHALL satisfy 2^SW >= CH.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port in_data, input, WIDTH bits: input beat payload.
REQ-007 Port in_sel, input, SW bits: destination channel for the current input beat.
REQ-008 Port in_valid, input, 1 bit: input beat present.
REQ-009 Port in_ready, output, 1 bit: block accepts the beat this cycle.
REQ-010 Port out_data, output, CH*WIDTH bits: channel k payload in bits [k*WIDTH +: WIDTH].
REQ-011 Port out_valid, output, CH bits: per-channel beat present.
REQ-012 Port out_ready, input, CH bits: per-channel sink accepts.
REQ-013 Port drop_cnt, output, 8 bits: count of discarded beats; present only with the macro in REQ-029.

Function
REQ-014 Each channel SHALL hold a one-entry output register (data plus valid flag); channel state is either EMPTY or FULL.
REQ-015 An input transfer SHALL occur when in_valid and in_ready are both 1 at a clock edge.
REQ-016 A channel k output transfer SHALL occur when out_valid[k] and out_ready[k] are both 1 at a clock edge.
REQ-017 For in_sel < CH, in_ready SHALL equal !out_valid[in_sel] | out_ready[in_sel], combinationally from current state and out_ready; no dependency on in_valid.
REQ-018 For in_sel >= CH, in_ready SHALL be 1 and the accepted beat SHALL be discarded, with no channel state change.
REQ-019 An accepted beat SHALL appear on out_data/out_valid of channel in_sel exactly one clock after the transfer edge (latency 1).
REQ-020 Transitions: EMPTY to FULL on input transfer to k; FULL to EMPTY on output transfer with no input transfer to k; FULL to FULL with new data on simultaneous output and input transfer to k; FULL holds otherwise.
REQ-021 Full throughput: one beat per clock to a channel whose out_ready is held 1, with no bubbles.
REQ-022 A FULL channel with out_ready[k]=0 SHALL hold out_data slice and out_valid[k] stable until transfer.
REQ-023 Channels SHALL be independent; a stalled channel SHALL NOT block beats to other channels.
REQ-024 in_data and in_sel SHALL be ignored when in_valid=0; out_data slices of EMPTY channels SHALL hold their last value.

Reset
REQ-025 While rst=1, all channels SHALL be EMPTY: out_valid = 0, out_data = 0, drop_cnt = 0; this takes effect immediately, without waiting for a clock edge.
REQ-026 A beat held in a channel at reset assertion SHALL be lost; no output transfer SHALL be reported for it.
REQ-027 During reset, in_ready SHALL follow REQ-017/REQ-018 against the EMPTY state, but no transfer SHALL take effect until the first edge after rst deasserts.
REQ-028 The first clock edge after rst deasserts SHALL be usable for an input transfer.

Configuration
REQ-029 With macro DEMUX_STREAM_DROPCNT_EN defined, drop_cnt SHALL exist and SHALL increment by 1 per beat discarded under REQ-018, saturating at 255.
REQ-030 Without DEMUX_STREAM_DROPCNT_EN, port drop_cnt and the counter SHALL be absent; discard behaviour of REQ-018 SHALL be unchanged.

Verification
REQ-031 Reset then a single beat, data 0xA5, sel 3, out_ready all 1 -> out_valid = 8'b0000_1000 and channel 3 data 0xA5 for exactly one cycle, one clock after acceptance.
REQ-032 Channel 5 out_ready=0; send 0x11 then 0x22 to sel 5 -> first beat accepted; in_ready=0 on the second; data 0x11 held; after out_ready[5]=1, 0x11 then 0x22 delivered in order.
REQ-033 Channel 2 stalled FULL; beat 0x33 to sel 6 -> accepted immediately; channel 6 valid next cycle; channel 2 unchanged.
REQ-034 Streaming, 16 consecutive beats 0..15 to sel 0, out_ready[0]=1 -> 16 consecutive output cycles, data 0..15, in_ready stays 1.
REQ-035 CH=6, SW=3, macro defined; 300 beats with sel 7 -> in_ready=1 throughout; no out_valid; drop_cnt saturates at 255.
REQ-036 rst asserted mid-cycle while channels 1 and 4 are FULL -> out_valid = 0 before the next edge; the held beats are never delivered.
